// File: rtl/mac_feeder.sv
// Sequences one job into a MAC column: loads N_PE weights, then streams k_len activations and flushes.
// Optional MAC_FEEDER_BIAS_EN adds a p_bias input that is latched at start and driven on p_o.
module mac_feeder #(
  parameter int unsigned N_PE = 3,
  parameter int unsigned AW   = 16,
  parameter int unsigned WW   = 8,
  parameter int unsigned PW   = 40
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [15:0]   k_len,
`ifdef MAC_FEEDER_BIAS_EN
  input  logic [PW-1:0] p_bias,
`endif
  input  logic          w_valid,
  output logic          w_ready,
  input  logic [WW-1:0] w_data,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_data,
  output logic          prefetch,
  output logic          conv,
  output logic [WW-1:0] w_o,
  output logic [AW-1:0] a_o,
  output logic [PW-1:0] p_o,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {IDLE, LOAD_W, GAP, STREAM, DRAIN, DONE} state_t;

  localparam logic [15:0] LP_NPE_M1 = 16'(N_PE - 1);

  state_t        r_state;
  state_t        w_next;
  logic [15:0]   r_w_cnt;
  logic [15:0]   r_a_cnt;
  logic [15:0]   r_d_cnt;
  logic [15:0]   r_k_len;
  logic          r_prefetch;
  logic          r_conv;
  logic [WW-1:0] r_w_o;
  logic [AW-1:0] r_a_o;
  logic          w_w_hs;
  logic          w_a_hs;

  assign w_ready = (r_state == LOAD_W);
  assign a_ready = (r_state == STREAM);
  assign busy    = (r_state != IDLE);
  assign done    = (r_state == DONE);
  assign w_w_hs  = w_valid & w_ready;
  assign w_a_hs  = a_valid & a_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = LOAD_W;
      LOAD_W:  if (w_w_hs && r_w_cnt == LP_NPE_M1) w_next = GAP;
      GAP:     w_next = (r_k_len == '0) ? DONE : STREAM;
      STREAM:  if (w_a_hs && r_a_cnt == r_k_len - 16'd1) w_next = DRAIN;
      DRAIN:   if (r_d_cnt == LP_NPE_M1) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_w_cnt <= '0;
      r_a_cnt <= '0;
      r_d_cnt <= '0;
      r_k_len <= '0;
    end else begin
      r_state <= w_next;
      // k_len and counters only move on start acceptance, so a start mid-job is inert
      if (r_state == IDLE && start) begin
        r_k_len <= k_len;
        r_w_cnt <= '0;
        r_a_cnt <= '0;
        r_d_cnt <= '0;
      end
      if (w_w_hs) r_w_cnt <= r_w_cnt + 16'd1;
      if (w_a_hs) r_a_cnt <= r_a_cnt + 16'd1;
      if (r_state == DRAIN) r_d_cnt <= r_d_cnt + 16'd1;
    end
  end

  // Column drive is registered one cycle behind the handshake / state that produces it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prefetch <= 1'b0;
      r_conv     <= 1'b0;
      r_w_o      <= '0;
      r_a_o      <= '0;
    end else begin
      r_prefetch <= w_w_hs;
      r_w_o      <= w_w_hs ? w_data : '0;
      r_conv     <= w_a_hs || (r_state == DRAIN);
      r_a_o      <= w_a_hs ? a_data : '0;
    end
  end

  assign prefetch = r_prefetch;
  assign conv     = r_conv;
  assign w_o      = r_w_o;
  assign a_o      = r_a_o;

`ifdef MAC_FEEDER_BIAS_EN
  logic [PW-1:0] r_bias;
  logic [PW-1:0] r_p_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bias <= '0;
      r_p_o  <= '0;
    end else begin
      if (r_state == IDLE && start) r_bias <= p_bias;
      r_p_o <= w_a_hs ? r_bias : '0;
    end
  end

  assign p_o = r_p_o;
`else
  assign p_o = '0;
`endif

endmodule

// File: tb/tb_mac_feeder.sv
// Table-driven job bench for mac_feeder with a scoreboard of expected column beats.
module tb_mac_feeder;
  localparam int N_PE = 3;
  localparam int AW   = 16;
  localparam int WW   = 8;
  localparam int PW   = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [15:0]   k_len;
  logic [PW-1:0] p_bias;
  logic          w_valid, w_ready;
  logic [WW-1:0] w_data;
  logic          a_valid, a_ready;
  logic [AW-1:0] a_data;
  logic          prefetch, conv;
  logic [WW-1:0] w_o;
  logic [AW-1:0] a_o;
  logic [PW-1:0] p_o;
  logic          busy, done;

  mac_feeder #(.N_PE(N_PE), .AW(AW), .WW(WW), .PW(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
`ifdef MAC_FEEDER_BIAS_EN
    .p_bias(p_bias),
`endif
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .prefetch(prefetch), .conv(conv), .w_o(w_o), .a_o(a_o), .p_o(p_o),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [PW-1:0] p;
  } exp_t;

  typedef struct {
    int            k;
    int            wgap;
    int            agap;
    bit            mid_start;
    bit            abort;
    logic [PW-1:0] bias;
    int            exp_lat;
  } job_t;

  logic [WW-1:0] q_w[$];
  exp_t          q_a[$];
  job_t          jobs[8];
  int unsigned   n_pass = 0;
  int unsigned   n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic run_job(input job_t j);
    int            wi, ai, wstall, astall, lat, pre_cnt, conv_cnt;
    int            bad_idle, bad_excl, bad_busy, cyc;
    bit            seen_done, ms_pending;
    logic [PW-1:0] exp_p;
    logic [WW-1:0] ew;
    exp_t          e;
    exp_t          ea;
`ifdef MAC_FEEDER_BIAS_EN
    exp_p = j.bias;
`else
    exp_p = '0;
`endif
    wi = 0; ai = 0; wstall = j.wgap; astall = j.agap; lat = 0;
    pre_cnt = 0; conv_cnt = 0; bad_idle = 0; bad_excl = 0; bad_busy = 0;
    seen_done = 0; ms_pending = 0; cyc = 0;
    @(negedge clk);
    start = 1'b1; k_len = 16'(j.k); p_bias = j.bias;
    while (!seen_done && cyc < 300) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (cyc == 0) begin
        start = 1'b0; k_len = 16'hBEEF; p_bias = ~j.bias;
      end
      if (ms_pending) begin
        start = 1'b0; k_len = 16'hBEEF; ms_pending = 0;
      end
      if (prefetch) begin
        pre_cnt++;
        if (q_w.size() == 0) chk("w_extra", 1, 0);
        else begin ew = q_w.pop_front(); chk("w_o", w_o, ew); end
      end else if (w_o != '0) bad_idle++;
      if (conv) begin
        conv_cnt++;
        if (q_a.size() == 0) chk("conv_extra", 1, 0);
        else begin
          ea = q_a.pop_front();
          chk("a_o", a_o, ea.a);
          chk("p_o", p_o, ea.p);
        end
      end else if (a_o != '0 || p_o != '0) bad_idle++;
      if (prefetch && conv) bad_excl++;
      if (busy !== 1'b1) bad_busy++;
      if (done) seen_done = 1;
      if (j.abort && a_ready && ai == 1) begin
        rst = 1'b1;
        #1;
        chk("rst_outs_zero", |{prefetch, conv, w_o, a_o, p_o, busy, done, w_ready, a_ready}, 0);
        @(negedge clk);
        rst = 1'b0; w_valid = 1'b0; a_valid = 1'b0;
        q_w.delete(); q_a.delete();
        repeat (3) @(negedge clk);
        chk("abort_idle", {busy, prefetch, conv}, 0);
        return;
      end
      if (j.mid_start && a_ready && ai == 0) begin
        start = 1'b1; k_len = 16'd7; ms_pending = 1;
      end
      // weights N_PE..1, optional stall after two accepted weights
      w_valid = 1'b0;
      if (wi < N_PE) begin
        if (wi == 2 && wstall > 0 && w_ready) wstall--;
        else begin
          w_valid = 1'b1; w_data = WW'(N_PE - wi);
          if (w_ready) begin q_w.push_back(w_data); wi++; end
        end
      end
      a_valid = 1'b0;
      if (ai < j.k) begin
        if (ai == 1 && astall > 0 && a_ready) astall--;
        else begin
          a_valid = 1'b1; a_data = AW'(ai + 1);
          if (a_ready) begin
            e.a = a_data; e.p = exp_p; q_a.push_back(e); ai++;
            if (ai == j.k) begin
              e.a = '0; e.p = '0;
              for (int d = 0; d < N_PE; d++) q_a.push_back(e);
            end
          end
        end
      end
      cyc++;
    end
    w_valid = 1'b0; a_valid = 1'b0;
    if (!seen_done) chk("done_timeout", 0, 1);
    chk("latency", lat, j.exp_lat);
    chk("prefetch_cnt", pre_cnt, N_PE);
    chk("conv_cnt", conv_cnt, (j.k == 0) ? 0 : j.k + N_PE);
    chk("queues_empty", q_w.size() + q_a.size(), 0);
    chk("idle_zero", bad_idle, 0);
    chk("exclusive", bad_excl, 0);
    chk("busy_in_job", bad_busy, 0);
    @(negedge clk);
    chk("done_pulse", {done, busy}, 0);
    q_w.delete(); q_a.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; k_len = '0; p_bias = '0;
    w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0;
    //            k  wgap agap mid abort bias     lat
    jobs[0] = '{3, 0, 0, 0, 0, 40'h1,   11};
    jobs[1] = '{3, 2, 0, 0, 0, 40'h5,   13};
    jobs[2] = '{0, 0, 0, 0, 0, 40'h9,    5};
    jobs[3] = '{4, 0, 1, 0, 0, 40'h3A,  13};
    jobs[4] = '{3, 0, 0, 1, 0, 40'h7,   11};
    jobs[5] = '{3, 0, 0, 0, 1, 40'h2,   11};
    jobs[6] = '{3, 0, 0, 0, 0, 40'h1,   11};
    jobs[7] = '{1, 0, 0, 0, 0, 40'hF0,   9};
    repeat (2) @(negedge clk);
    chk("reset_outs", |{prefetch, conv, w_o, a_o, p_o, busy, done, w_ready, a_ready}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {busy, w_ready, a_ready}, 0);
    for (int i = 0; i < 8; i++) run_job(jobs[i]);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/mac_feeder.md
MAC_FEEDER -- requirements
Module: mac_feeder

Interface
REQ-001 Parameter N_PE, default 3: number of MAC stages in the driven column, which equals the weights loaded per job.
REQ-002 Parameter AW, default 16: activation width.
REQ-003 Parameter WW, default 8: weight width.
REQ-004 Parameter PW, default 40: partial-sum width.
REQ-005 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 Port start, input, 1 bit: job start request; sampled only in IDLE.
REQ-008 Port k_len, input, 16 bits: activation count for the job; latched when start is accepted.
REQ-009 Ports w_valid (input, 1), w_ready (output, 1), w_data (input, WW): weight stream, valid/ready.
REQ-010 Ports a_valid (input, 1), a_ready (output, 1), a_data (input, AW): activation stream, valid/ready.
REQ-011 Ports prefetch (output, 1), conv (output, 1), w_o (output, WW), a_o (output, AW), p_o (output, PW): column drive, all registered.
REQ-012 Ports busy (output, 1) and done (output, 1): status; done is a one-cycle pulse.

Function
REQ-013 FSM states SHALL be IDLE, LOAD_W, GAP, STREAM, DRAIN and DONE.
- IDLE->LOAD_W on start.
- LOAD_W->GAP after N_PE accepted weights.
- GAP->STREAM after 1 cycle, or GAP->DONE if k_len==0.
- STREAM->DRAIN after k_len accepted activations.
- DRAIN->DONE after N_PE cycles.
- DONE->IDLE after 1 cycle.
REQ-014 w_ready SHALL be 1 only in LOAD_W, and a_ready only in STREAM; both are combinational from state.
REQ-015 A weight accepted at cycle t (w_valid&w_ready) SHALL produce prefetch=1 and w_o=w_data in cycle t+1; cycles without a weight handshake give prefetch=0, w_o=0.
REQ-016 GAP SHALL drive prefetch=0 and conv=0 for exactly one cycle.
REQ-017 An activation accepted at cycle t SHALL produce conv=1, a_o=a_data and p_o=bias value in cycle t+1; stall cycles give conv=0, a_o=0, p_o=0.
REQ-018 DRAIN SHALL drive conv=1, a_o=0 and p_o=0 for N_PE cycles to flush the column.
REQ-019 prefetch and conv SHALL never both be 1 in the same cycle.
REQ-020 busy SHALL be 1 in every state except IDLE; done SHALL be 1 only in DONE.
REQ-021 start while not in IDLE SHALL be ignored, with no effect on counters or latched k_len.
REQ-022 The weight and activation counters SHALL be 16-bit, SHALL clear on entry to LOAD_W, and SHALL not wrap within a job.

Reset
REQ-023 While rst=1, state SHALL be IDLE, counters 0, latched k_len 0, and every output 0 (prefetch, conv, w_o, a_o, p_o, busy, done, w_ready, a_ready).
REQ-024 Reset asserted mid-job SHALL abort immediately; a partial job SHALL not resume, and the next job requires a new start.

Configuration
REQ-025 Macro MAC_FEEDER_BIAS_EN defined: a port p_bias (input, PW) SHALL exist, be latched on start acceptance, and be driven on p_o for every conv cycle carrying an activation.
REQ-026 Macro MAC_FEEDER_BIAS_EN undefined: the p_bias port SHALL be absent and p_o SHALL be constant 0.

Verification
REQ-027 Reset mid-STREAM -> all outputs 0 in the same cycle; FSM in IDLE; new start with weights 3,2,1 completes normally.
REQ-028 Nominal job: N_PE=3, k_len=3, weights 3,2,1, activations 1,2,3, valids always high -> prefetch=1 for 3 cycles with w_o 3,2,1, then 1 GAP cycle, then conv=1 with a_o 1,2,3, then 3 drain cycles, then done pulse; 11 cycles from start to done.
REQ-029 w_valid low for 2 cycles between weights 2 and 1 -> prefetch=0 and w_o=0 in those 2 cycles; the third weight is still loaded and the FSM waits in LOAD_W.
REQ-030 k_len=0 with weights 3,2,1 -> no conv=1 cycle, a_ready never 1, done asserted 1 cycle after GAP.
REQ-031 MAC_FEEDER_BIAS_EN defined, p_bias=1 at start, activations 1,2,3 -> p_o=1 on all three conv-with-data cycles and 0 during drain; undefined -> p_o=0 throughout.
REQ-032 start pulsed during STREAM with a different k_len=7 -> ignored; the job ends after the original 3 activations.
